// File: rtl/score_board.sv
// Animated multi-digit BCD score counter with seven-segment on-screen rendering.
// Optional build macro: LEADING_ZERO_BLANK_EN (hide digits above the highest nonzero one).

module single_number #(
  parameter logic [9:0]  H_POS = 10'd0,
  parameter logic [9:0]  V_POS = 10'd0,
  parameter logic [23:0] COLOR = 24'hffffff
) (
  input  logic [9:0]  hcounter,
  input  logic [9:0]  vcounter,
  input  logic [3:0]  digit,
  input  logic        enable,
  output logic        visible,
  output logic [23:0] rgb
);
  // Glyph box is 40x60 with 8-pixel strokes; segment order {a,b,c,d,e,f,g}
  localparam logic [9:0] W = 10'd40;
  localparam logic [9:0] H = 10'd60;
  localparam logic [9:0] T = 10'd8;

  logic [9:0] rx, ry;
  logic       in_box, row_a, row_d, row_g, col_l, col_r, upper, lit;
  logic [6:0] seg;

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = '0;
    endcase
  end

  always_comb begin
    rx     = hcounter - H_POS;
    ry     = vcounter - V_POS;
    in_box = (hcounter >= H_POS) && (rx < W) && (vcounter >= V_POS) && (ry < H);
    row_a  = ry < T;
    row_d  = ry >= (H - T);
    row_g  = (ry >= 10'd26) && (ry < 10'd34);
    col_l  = rx < T;
    col_r  = rx >= (W - T);
    upper  = ry < 10'd30;
    lit    = (seg[6] & row_a)          | (seg[5] & col_r & upper) |
             (seg[4] & col_r & ~upper) | (seg[3] & row_d)         |
             (seg[2] & col_l & ~upper) | (seg[1] & col_l & upper) |
             (seg[0] & row_g);
    visible = enable & in_box & lit;
    rgb     = visible ? COLOR : '0;
  end
endmodule

module score_board #(
  parameter int          DIGITS      = 3,
  parameter int          PEND_W      = 5,
  parameter int          TICK_DIV    = 4,
  parameter logic [9:0]  H_POS       = 10'd40,
  parameter logic [9:0]  V_POS       = 10'd320,
  parameter logic [9:0]  DIGIT_PITCH = 10'd60,
  parameter logic [23:0] COLOR       = 24'hed5a65
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                hit_success,
  input  logic [2:0]          round_score,
  input  logic [9:0]          hcounter,
  input  logic [9:0]          vcounter,
  output logic                visible,
  output logic [23:0]         rgb,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic                busy,
  output logic                saturated
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W = PEND_W + 3;
  localparam logic [SUM_W-1:0] PEND_MAX = {3'b000, {PEND_W{1'b1}}};

  typedef enum logic {IDLE, COUNT} state_t;

  state_t              state, state_next;
  logic [4*DIGITS-1:0] score_q, score_next, score_inc;
  logic [PEND_W-1:0]   pend_q, pend_next;
  logic [CNT_W-1:0]    cnt_q, cnt_next;
  logic                sat_q, sat_next;
  logic                step, carry;
  logic [SUM_W-1:0]    sum;

  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_inc[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = '0;
        end else begin
          score_inc[4*i +: 4] = score_inc[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    step       = (state == COUNT) && (cnt_q == CNT_W'(TICK_DIV - 1));
    score_next = score_q;
    pend_next  = pend_q;
    cnt_next   = cnt_q;
    sat_next   = sat_q;
    sum        = '0;
    if (clear) begin
      score_next = '0;
      pend_next  = '0;
      cnt_next   = '0;
      sat_next   = 1'b0;
    end else if (step && carry) begin
      // A carry out of the top digit means the score is all-9s: hold it and drop the queue
      sat_next  = 1'b1;
      pend_next = '0;
      cnt_next  = '0;
    end else begin
      if (step)
        score_next = score_inc;
      sum = {3'b000, pend_q}
          + ((hit_success && !sat_q) ? SUM_W'(round_score) : '0)
          - SUM_W'(step);
      pend_next = (sum > PEND_MAX) ? '1 : sum[PEND_W-1:0];
      if (state == COUNT)
        cnt_next = step ? '0 : cnt_q + CNT_W'(1);
      if (pend_next == '0)
        cnt_next = '0;
    end
    state_next = (pend_next != '0) ? COUNT : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      score_q <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state   <= state_next;
      score_q <= score_next;
      pend_q  <= pend_next;
      cnt_q   <= cnt_next;
      sat_q   <= sat_next;
    end
  end

  assign score_bcd = score_q;
  assign busy      = (state == COUNT);
  assign saturated = sat_q;

  logic [DIGITS-1:0] en, dvis;
  logic [23:0]       drgb [DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [9:0] X = 10'(int'(H_POS) + (DIGITS - 1 - i) * int'(DIGIT_PITCH));
`ifdef LEADING_ZERO_BLANK_EN
    if (i == 0) begin : g_lsd
      assign en[i] = 1'b1;
    end else begin : g_upper
      assign en[i] = |score_q[4*DIGITS-1:4*i];
    end
`else
    assign en[i] = 1'b1;
`endif
    single_number #(
      .H_POS(X),
      .V_POS(V_POS),
      .COLOR(COLOR)
    ) u_num (
      .hcounter(hcounter),
      .vcounter(vcounter),
      .digit   (score_q[4*i +: 4]),
      .enable  (en[i]),
      .visible (dvis[i]),
      .rgb     (drgb[i])
    );
  end

  always_comb begin
    visible = 1'b0;
    rgb     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dvis[i] && !visible) begin
        visible = 1'b1;
        rgb     = drgb[i];
      end
    end
  end
endmodule

// File: tb/tb_score_board.sv
// Self-checking bench for score_board: a 3-digit and a 2-digit instance share stimulus and
// are compared every cycle against an integer-arithmetic model of score, queue and display.
module tb_score_board;
  localparam int TD    = 4;
  localparam int PMAX  = 31;
  localparam logic [23:0] COLOR = 24'hed5a65;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, hit_success = 1'b0;
  logic [2:0]  round_score = '0;
  logic [9:0]  hcounter = '0, vcounter = '0;
  logic        vis1, vis2, busy1, busy2, sat1, sat2;
  logic [23:0] rgb1, rgb2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;

  int checks = 0, errors = 0;
  bit chk_en = 0, pix_rand = 1;

  int m_score[2], m_pend[2], m_cnt[2];
  bit m_sat[2];
  int m_max[2] = '{999, 99};
  int m_dig[2] = '{3, 2};
  string glyph[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  always #5 clk = ~clk;

  score_board #(.DIGITS(3), .PEND_W(5), .TICK_DIV(TD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .hit_success(hit_success),
    .round_score(round_score), .hcounter(hcounter), .vcounter(vcounter),
    .visible(vis1), .rgb(rgb1), .score_bcd(bcd1), .busy(busy1), .saturated(sat1));

  score_board #(.DIGITS(2), .PEND_W(5), .TICK_DIV(TD)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .hit_success(hit_success),
    .round_score(round_score), .hcounter(hcounter), .vcounter(vcounter),
    .visible(vis2), .rgb(rgb2), .score_bcd(bcd2), .busy(busy2), .saturated(sat2));

  task automatic model_step(input int k);
    bit step;
    int p;
    if (clear) begin
      m_score[k] = 0; m_pend[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
      return;
    end
    step = (m_pend[k] != 0) && (m_cnt[k] == TD - 1);
    if (step && m_score[k] == m_max[k]) begin
      m_sat[k] = 1; m_pend[k] = 0; m_cnt[k] = 0;
      return;
    end
    if (step) m_score[k]++;
    p = m_pend[k] + ((hit_success && !m_sat[k]) ? int'(round_score) : 0) - int'(step);
    if (p > PMAX) p = PMAX;
    if (m_pend[k] != 0) m_cnt[k] = step ? 0 : m_cnt[k] + 1;
    if (p == 0) m_cnt[k] = 0;
    m_pend[k] = p;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_score[k] = 0; m_pend[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic bit in_seg(input byte s, input int rx, input int ry);
    case (s)
      "a": return ry < 8;
      "b": return rx >= 32 && ry < 30;
      "c": return rx >= 32 && ry >= 30;
      "d": return ry >= 52;
      "e": return rx < 8 && ry >= 30;
      "f": return rx < 8 && ry < 30;
      "g": return ry >= 26 && ry < 34;
      default: return 0;
    endcase
  endfunction

  function automatic bit pixel_on(input int score, input int ndig, input int h, input int v);
    for (int i = 0; i < ndig; i++) begin
      int x0 = 40 + (ndig - 1 - i) * 60;
      int d  = (score / (10 ** i)) % 10;
      bit shown = 1;
`ifdef LEADING_ZERO_BLANK_EN
      shown = (i == 0) || (score >= 10 ** i);
`endif
      if (shown && h >= x0 && h < x0 + 40 && v >= 320 && v < 380)
        for (int j = 0; j < glyph[d].len(); j++)
          if (in_seg(glyph[d][j], h - x0, v - 320)) return 1;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      bit p1, p2;
      p1 = pixel_on(m_score[0], 3, int'(hcounter), int'(vcounter));
      p2 = pixel_on(m_score[1], 2, int'(hcounter), int'(vcounter));
      chk("d1_score", {20'b0, bcd1}, to_bcd(m_score[0]));
      chk("d1_busy", {31'b0, busy1}, {31'b0, m_pend[0] != 0});
      chk("d1_sat", {31'b0, sat1}, {31'b0, m_sat[0]});
      chk("d1_vis", {31'b0, vis1}, {31'b0, p1});
      chk("d1_rgb", {8'b0, rgb1}, p1 ? {8'b0, COLOR} : 32'b0);
      chk("d2_score", {24'b0, bcd2}, to_bcd(m_score[1]));
      chk("d2_busy", {31'b0, busy2}, {31'b0, m_pend[1] != 0});
      chk("d2_sat", {31'b0, sat2}, {31'b0, m_sat[1]});
      chk("d2_vis", {31'b0, vis2}, {31'b0, p2});
      chk("d2_rgb", {8'b0, rgb2}, p2 ? {8'b0, COLOR} : 32'b0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pix_rand) begin
      hcounter = 10'($urandom_range(30, 230));
      vcounter = 10'($urandom_range(310, 390));
    end
  endtask

  task automatic hit(input int rs);
    hit_success = 1'b1; round_score = 3'(rs);
    cyc();
    hit_success = 1'b0; round_score = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (m_pend[0] == 0 && m_pend[1] == 0) done = 1;
      else cyc();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle: queue still pending (%0d) after cycle budget", m_pend[0]);
    end
  endtask

  task automatic add_points(input int n);
    int left = n;
    for (int b = 0; b < 5000 && left > 0; b++) begin
      int k = (left < 7) ? left : 7;
      if (m_pend[0] + k <= 30) begin
        hit_success = 1'b1; round_score = 3'(k); left -= k;
      end else begin
        hit_success = 1'b0;
      end
      cyc();
    end
    hit_success = 1'b0; round_score = '0;
    wait_idle();
  endtask

  task automatic probe(input int h, input int v, input bit exp_vis);
    hcounter = 10'(h); vcounter = 10'(v);
    #1;
    chk("probe_vis", {31'b0, vis1}, {31'b0, exp_vis});
    chk("probe_rgb", {8'b0, rgb1}, exp_vis ? {8'b0, COLOR} : 32'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    chk("reset_score", {20'b0, bcd1}, 32'h0);
    chk("reset_busy", {31'b0, busy1}, 32'h0);

    // Queueing: 5 then 3 two cycles later, eight steps four clocks apart
    hit_success = 1'b1; round_score = 3'd5; cyc();
    hit_success = 1'b0; cyc();
    hit(3);
    repeat (29) cyc();
    chk("queue_score_7", {20'b0, bcd1}, 32'h007);
    chk("queue_busy_7", {31'b0, busy1}, 32'h1);
    cyc();
    chk("queue_score_8", {20'b0, bcd1}, 32'h008);
    chk("queue_busy_8", {31'b0, busy1}, 32'h0);

    // Asynchronous reset in the middle of a count
    hit(7);
    repeat (6) cyc();
    pix_rand = 0; hcounter = '0; vcounter = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_score", {20'b0, bcd1}, 32'h0);
    chk("areset_busy", {31'b0, busy1}, 32'h0);
    chk("areset_sat", {31'b0, sat1}, 32'h0);
    chk("areset_rgb", {8'b0, rgb1}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; pix_rand = 1;

    // BCD carry chains
    add_points(99);
    chk("carry_099", {20'b0, bcd1}, 32'h099);
    add_points(1);
    chk("carry_100", {20'b0, bcd1}, 32'h100);
    chk("d2_sat_at_100", {31'b0, sat2}, 32'h1);
    add_points(99);
    add_points(1);
    chk("carry_200", {20'b0, bcd1}, 32'h200);

    // Saturation of the two-digit instance
    do_clear();
    add_points(97);
    chk("sat_97", {24'b0, bcd2}, 32'h97);
    hit(7);
    wait_idle();
    chk("sat_99", {24'b0, bcd2}, 32'h99);
    chk("sat_flag", {31'b0, sat2}, 32'h1);
    hit(4);
    repeat (20) cyc();
    chk("sat_hold", {24'b0, bcd2}, 32'h99);
    chk("sat_d1_108", {20'b0, bcd1}, 32'h108);
    do_clear();
    chk("sat_clear", {24'b0, bcd2}, 32'h0);
    chk("sat_clear_flag", {31'b0, sat2}, 32'h0);

    // Hit landing on a step edge, then clear together with a hit
    hit(1);
    repeat (3) cyc();
    hit(2);
    chk("simul_score_1", {20'b0, bcd1}, 32'h001);
    chk("simul_busy", {31'b0, busy1}, 32'h1);
    repeat (8) cyc();
    chk("simul_score_3", {20'b0, bcd1}, 32'h003);
    chk("simul_idle", {31'b0, busy1}, 32'h0);
    hit(5);
    clear = 1'b1; hit_success = 1'b1; round_score = 3'd7; cyc();
    clear = 1'b0; hit_success = 1'b0; round_score = '0;
    chk("clear_hit_score", {20'b0, bcd1}, 32'h0);
    chk("clear_hit_busy", {31'b0, busy1}, 32'h0);

    // Display of 042
    add_points(42);
    pix_rand = 0;
`ifdef LEADING_ZERO_BLANK_EN
    probe(60, 322, 0);
`else
    probe(60, 322, 1);
`endif
    probe(104, 330, 1);
    probe(120, 322, 0);
    probe(180, 322, 1);
    probe(0, 0, 0);
    pix_rand = 1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 199);
      clear       = (r == 0);
      hit_success = (r >= 1 && r < 60);
      round_score = 3'($urandom_range(0, 7));
      cyc();
    end
    clear = 1'b0; hit_success = 1'b0;
    wait_idle();
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
